// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes, bridge states, default widths.
package axi4l_pkg;

  localparam int unsigned AXI_ADDR_W_DEF  = 32;
  localparam int unsigned AXI_DATA_W_DEF  = 32;
  localparam int unsigned WDOG_CYCLES_DEF = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;

  // States in which the bridge is waiting on the slave.
  function automatic logic is_busy(input state_e s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi4l_wdog.sv
// Handshake watchdog: saturating wait counter with a sticky error flag.
module axi4l_wdog
  import axi4l_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic state_change,
  output logic wdog_err
);

  localparam logic [15:0] LIMIT = 16'(WDOG_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Count wait cycles within one state; flag once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_change) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (busy && (cnt_q >= LIMIT)) begin
      err_d = 1'b1;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign wdog_err = err_q;

endmodule

// File: rtl/axi4l_master_bridge.sv
// Single-outstanding CPU command/response to AXI4-Lite initiator bridge.
module axi4l_master_bridge
  import axi4l_pkg::*;
#(
  parameter int unsigned ADDR_W      = AXI_ADDR_W_DEF,
  parameter int unsigned DATA_W      = AXI_DATA_W_DEF,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                wdog_err,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_pend, w_pend;

  // Next-state and next-output logic; every output is driven from a flop.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_pend     = awvalid_q & ~AWREADY;
    w_pend      = wvalid_q & ~WREADY;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      // AW and W complete independently; leave once neither is pending.
      WR_REQ: begin
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = BRESP;
        end
      end
      RD_ADDR: begin
        if (ARREADY) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (RVALID) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  axi4l_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk         (ACLK),
    .rst         (ARESET),
    .busy        (is_busy(state_q)),
    .state_change(state_d != state_q),
    .wdog_err    (wdog_err)
  );

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = addr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = addr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// Directed bench for axi4l_master_bridge with a hand-driven AXI slave.
module tb_axi4l_master_bridge;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        wdog_err;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  axi4l_master_bridge #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .WDOG_CYCLES(8)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .wdog_err(wdog_err),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    check("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    step();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_after_consume", rsp_valid, 0);
    check("cmd_ready_after_consume", cmd_ready, 1);
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
    BRESP = '0; ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
    repeat (2) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
    check("rst_wdog", wdog_err, 0);
    check("rst_regs", {AWADDR, WDATA, WSTRB}, 0);
    ARESET = 1'b0;
    step();

    // 1: zero-wait write
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    check("t1_c1_valids", {AWVALID, WVALID}, 2'b11);
    check("t1_c1_awaddr", AWADDR, 32'h10);
    check("t1_c1_wdata", WDATA, 32'hDEAD_BEEF);
    check("t1_c1_wstrb", WSTRB, 4'hF);
    check("t1_c1_cmd_ready", cmd_ready, 0);
    AWREADY = 1; WREADY = 1;
    step();
    AWREADY = 0; WREADY = 0;
    check("t1_c2_valids", {AWVALID, WVALID}, 2'b00);
    check("t1_c2_bready", BREADY, 1);
    check("t1_c2_rsp_valid", rsp_valid, 0);
    BVALID = 1; BRESP = 2'b00;
    step();
    BVALID = 0;
    check("t1_c3_rsp_valid", rsp_valid, 1);
    check("t1_c3_payload", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
    check("t1_c3_bready", BREADY, 0);
    consume();

    // 2: split handshake, W at cycle 1, AW at cycle 4
    issue(1'b1, 32'h0000_0020, 32'hA5A5_0001, 4'h3);
    check("t2_c1_valids", {AWVALID, WVALID}, 2'b11);
    check("t2_c1_wdata", {WDATA, WSTRB}, {32'hA5A5_0001, 4'h3});
    WREADY = 1;
    step();
    WREADY = 0;
    for (int c = 2; c <= 4; c++) begin
      check("t2_wvalid_low", WVALID, 0);
      check("t2_awvalid_held", AWVALID, 1);
      check("t2_awaddr_stable", AWADDR, 32'h20);
      check("t2_bready_low", BREADY, 0);
      if (c == 4) AWREADY = 1;
      step();
      AWREADY = 0;
    end
    check("t2_c5_awvalid", AWVALID, 0);
    check("t2_c5_bready", BREADY, 1);
    BVALID = 1; BRESP = 2'b01;
    step();
    BVALID = 0;
    check("t2_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {2'b11, 2'b01, 32'h0});
    consume();

    // 3: read with wait states
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    for (int c = 1; c <= 3; c++) begin
      check("t3_arvalid", ARVALID, 1);
      check("t3_araddr", ARADDR, 32'h100);
      check("t3_no_write", {AWVALID, WVALID}, 0);
      step();
    end
    ARREADY = 1;
    check("t3_arvalid_c4", ARVALID, 1);
    step();
    ARREADY = 0;
    check("t3_arvalid_dropped", ARVALID, 0);
    for (int c = 5; c <= 6; c++) begin
      check("t3_rready", RREADY, 1);
      step();
    end
    RVALID = 1; RDATA = 32'h1234_5678; RRESP = 2'b10;
    step();
    RVALID = 0; RDATA = '0; RRESP = '0;
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_payload", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'h1234_5678});
    check("t3_rready_low", RREADY, 0);

    // 4: response backpressure for 20 cycles
    for (int c = 0; c < 20; c++) begin
      step();
      check("t4_rsp_valid", rsp_valid, 1);
      check("t4_payload", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'h1234_5678});
      check("t4_cmd_ready", cmd_ready, 0);
      check("t4_wdog", wdog_err, 0);
    end
    consume();

    // 5: watchdog with ARREADY withheld
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    for (int c = 1; c <= 8; c++) begin
      check("t5_arvalid", ARVALID, 1);
      check("t5_wdog_clear", wdog_err, 0);
      step();
    end
    check("t5_wdog_set", wdog_err, 1);
    check("t5_arvalid_kept", ARVALID, 1);
    step();
    step();
    ARREADY = 1;
    step();
    ARREADY = 0;
    check("t5_rready", RREADY, 1);
    RVALID = 1; RDATA = 32'hCAFE_F00D; RRESP = 2'b00;
    step();
    RVALID = 0;
    check("t5_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {2'b10, 2'b00, 32'hCAFE_F00D});
    check("t5_wdog_sticky", wdog_err, 1);
    consume();
    check("t5_wdog_sticky_idle", wdog_err, 1);

    // 6: reset during WR_REQ
    issue(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hC);
    check("t6_in_wr_req", {AWVALID, WVALID}, 2'b11);
    ARESET = 1;
    step();
    ARESET = 0;
    check("t6_valids", {AWVALID, WVALID}, 2'b00);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_wdog", wdog_err, 0);
    check("t6_regs", {AWADDR, WDATA, WSTRB}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4l_master_bridge.md
Name: axi4l_master_bridge

Overview:
- AXI4-Lite initiator that drives the DDR2 controller's AXI4-Lite slave ports.
- Converts a single-outstanding command/response interface from the CPU side into AXI4-Lite read and write transactions.
- Returns read data and response codes to the CPU side.
- A watchdog flags a slave that stalls, but never abandons a transaction.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; WSTRB width is DATA_W/8.
- WDOG_CYCLES, 1024, cycles of waiting on any single handshake before wdog_err is set.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  byte enables
- rsp_valid  out  1  response available
- rsp_ready  in  1  CPU consumes response
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  RRESP/BRESP copy
- wdog_err  out  1  sticky watchdog flag
- AWADDR  out  ADDR_W
- AWVALID  out  1
- AWREADY  in  1
- WDATA  out  DATA_W
- WSTRB  out  DATA_W/8
- WVALID  out  1
- WREADY  in  1
- BRESP  in  2
- BVALID  in  1
- BREADY  out  1
- ARADDR  out  ADDR_W
- ARVALID  out  1
- ARREADY  in  1
- RDATA  in  DATA_W
- RRESP  in  2
- RVALID  in  1
- RREADY  out  1
- Interface decision: one clock, ACLK; reset ARESET is synchronous and active-high.

Behaviour:
- Reset values (synchronous on ARESET=1 at a rising ACLK edge):
  - State = IDLE.
  - All VALID outputs, BREADY, RREADY and rsp_valid = 0.
  - cmd_ready = 1.
  - wdog_err = 0.
  - All address, data and strobe registers = 0.
- Reset mid-transaction drops everything immediately. The system resets slave and master together.
- cmd_ready = 1 only in IDLE.
  - On accept, cmd_addr, cmd_wdata, cmd_wstrb and cmd_write are registered.
  - AXI VALIDs rise on the next cycle; there is no combinational path from cmd_* to AXI outputs.
- IDLE -> WR_REQ on a write accept. IDLE -> RD_ADDR on a read accept.
- WR_REQ:
  - AWVALID and WVALID are both asserted.
  - Each drops independently after its own handshake; AWREADY and WREADY may arrive in any order or in the same cycle.
  - Go to WR_RESP when both handshakes are done, i.e. the cycle after the later one.
  - AWADDR, WDATA and WSTRB stay stable while their VALID is high.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: capture BRESP, set rsp_write=1 and rsp_rdata=0, go to RSP.
- RD_ADDR:
  - ARVALID = 1.
  - On ARREADY, go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID: capture RDATA and RRESP, set rsp_write=0, go to RSP.
- RSP:
  - rsp_valid = 1, with payload held stable.
  - On rsp_ready, go to IDLE; cmd_ready rises on the following cycle.
  - Minimum spacing between command accepts is therefore 4 cycles for reads and 4 for writes when slaves are zero-wait.
- Latency with zero-wait slave:
  - Accept at cycle 0.
  - VALID at cycle 1.
  - B or R handshake at cycle 2 at earliest.
  - rsp_valid at cycle 3.
- VALID rule: VALID is never deasserted before its READY, regardless of watchdog or any other condition.
- Watchdog:
  - 16-bit cycle counter, cleared on every state change.
  - It increments in WR_REQ, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches WDOG_CYCLES-1, wdog_err sets and stays set until ARESET.
  - The counter saturates.
  - The counter does not run in RSP; CPU backpressure is not a fault.
- Response codes are passed through unmodified. SLVERR and DECERR are not retried.
- AWPROT and ARPROT are not driven by this block; the top level ties them to 3'b000.

Decomposition:
- Shared package axi4l_pkg holds:
  - Response constants RESP_OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - State enum IDLE/WR_REQ/WR_RESP/RD_ADDR/RD_DATA/RSP.
  - Default widths.
- Sub-module axi4l_wdog: counter, saturate and sticky flag, with inputs busy and state_change.

Test Plan:
1. Zero-wait write: cmd addr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=0xF.
   - AWVALID and WVALID rise at cycle 1 with the same values.
   - Slave BRESP=00.
   - rsp_valid at cycle 3 with rsp_write=1, rsp_resp=00, rsp_rdata=0.
2. Split handshake: WREADY at cycle 1, AWREADY at cycle 4.
   - WVALID drops at cycle 2; AWVALID is held until 4.
   - BREADY rises at cycle 5.
   - Data and address never change while their VALID is high.
3. Read with wait states: addr=0x0000_0100, ARREADY after 3 cycles, RVALID after 2 more with RDATA=0x1234_5678, RRESP=10.
   - Response returns 0x1234_5678 with rsp_resp=10.
4. Response backpressure: rsp_ready held low 20 cycles.
   - rsp_valid and payload are held stable; cmd_ready=0 throughout; wdog_err stays 0.
   - cmd_ready=1 the cycle after rsp_ready.
5. Watchdog with WDOG_CYCLES=8: ARREADY never asserted.
   - wdog_err=1 after exactly 8 RD_ADDR cycles; ARVALID stays 1.
   - A later ARREADY completes the read normally, and wdog_err remains 1.
6. Reset mid-write: ARESET in WR_REQ cycle.
   - Next cycle AWVALID=WVALID=0, state IDLE, cmd_ready=1, wdog_err=0.
